axis_out_downsizer: RTL and testbench
=====================================

Name: axis_out_downsizer

Overview:
Output-side width converter that sits directly downstream of the matrix-multiply core's 128-bit result stream (8 × Q8.8 lanes per beat). It splits each wide result beat into RATIO narrow AXI-Stream beats for the 64-bit DMA write path, preserving frame boundaries via tlast. It holds one wide beat in a holding register so that it sustains full narrow-side throughput without bubbles. It also counts completed output frames for software status.

Parameters:
IN_WIDTH, 128, width of input tdata (result beat from core)
OUT_WIDTH, 64, width of output tdata; IN_WIDTH must equal RATIO*OUT_WIDTH with RATIO ≥ 2
RATIO, IN_WIDTH/OUT_WIDTH, derived (localparam); index counter width = max(1, clog2(RATIO))
FRAME_CNT_W, 16, width of frame counter

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  IN_WIDTH  wide result beat
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  last wide beat of frame
s_axis_tready  out  1  input ready
m_axis_tdata  out  OUT_WIDTH  narrow output beat
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last narrow beat of frame
m_axis_tready  in  1  downstream ready
frame_cnt  out  FRAME_CNT_W  number of completed output frames, wrapping

Behaviour:
- Reset (aresetn low, asynchronous, any cycle including mid-frame): the holding register, buf_last, busy and idx are cleared and frame_cnt = 0. Outputs after reset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, s_axis_tready = 1. A partially emitted beat is discarded and is not replayed.
- State: busy (holding register occupied), idx (0..RATIO-1, current slice), buf (IN_WIDTH), buf_last.
- Output mapping (registered state, combinational decode):
  - m_axis_tvalid = busy
  - m_axis_tdata = buf[idx*OUT_WIDTH +: OUT_WIDTH]; the least-significant slice is emitted first.
  - m_axis_tlast = busy && buf_last && (idx == RATIO-1)
- Output handshake: out_fire = m_axis_tvalid && m_axis_tready.
- Input handshake: s_axis_tready = !busy || (out_fire && idx == RATIO-1). This is a combinational path from m_axis_tready; it allows back-to-back wide beats with zero idle narrow cycles. in_fire = s_axis_tvalid && s_axis_tready.
- Per-cycle update:
  - in_fire: buf <= s_axis_tdata, buf_last <= s_axis_tlast, idx <= 0, busy <= 1. This takes priority over the out_fire updates below; the simultaneous final-slice-out / new-beat-in case is the steady state.
  - Else if out_fire and idx == RATIO-1: busy <= 0, idx <= 0.
  - Else if out_fire: idx <= idx + 1.
  - Else: hold.
- Latency: the first narrow beat is valid the cycle after in_fire. Sustained throughput is 1 narrow beat per cycle, i.e. 1 wide beat per RATIO cycles.
- AXI stability: while m_axis_tvalid && !m_axis_tready, tdata and tlast are held unchanged. tvalid never deasserts without a handshake except on reset.
- Data bits are passed through unmodified; there is no arithmetic on lane contents.
- frame_cnt increments by 1 on each cycle with out_fire && m_axis_tlast. It wraps from 2^FRAME_CNT_W-1 to 0.
- s_axis_tlast on a non-valid cycle is ignored. A frame of N wide beats yields exactly N*RATIO narrow beats, with a single tlast on the final one.
- When busy = 0, m_axis_tdata shows the stale holding-register slice and its value is don't-care (0 only after reset).

Test Plan:
1. Reset then single beat: s_axis_tdata = 128'h02000100020002000100020001000100, tlast = 1, tready held 1 → cycle+1 m_axis_tdata = 64'h0100020001000100 with tlast 0; cycle+2 m_axis_tdata = 64'h0200010002000200 with tlast 1; frame_cnt = 1; tvalid low at cycle+3.
2. Back-to-back frame: 4 wide beats with s_axis_tvalid held 1 and tlast on beat 4, m_axis_tready = 1 → 8 consecutive narrow beats with no gaps; s_axis_tready pulses every 2nd cycle; tlast only on narrow beat 8; frame_cnt increments once.
3. Backpressure: m_axis_tready = 0 for 5 cycles mid-beat (idx = 1) → tdata, tvalid and tlast are stable; s_axis_tready = 0; on release, 64'h0200010002000200 is accepted and the next wide beat is accepted in the same cycle.
4. Reset mid-frame: assert aresetn = 0 while idx = 1 of a tlast beat → tvalid and tlast drop immediately (asynchronous); frame_cnt = 0; after release s_axis_tready = 1 and no residual beat is emitted.
5. Random valid/ready toggling over 200 wide beats → the narrow stream equals each wide beat split low slice first; tlast count equals the input tlast count; frame_cnt matches.
6. Frame counter wrap with FRAME_CNT_W = 2: send 5 single-beat frames → frame_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/axis_out_downsizer.sv
// axis_out_downsizer: splits each wide AXI-Stream beat into RATIO narrow beats (low slice first) and counts frames
module axis_out_downsizer #(
    parameter int IN_WIDTH = 128,
    parameter int OUT_WIDTH = 64,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [IN_WIDTH-1:0]    s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [OUT_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    logic [IN_WIDTH-1:0] hold;
    logic                hold_last;
    logic                busy;
    logic [IDX_W-1:0]    idx;
    logic                at_end;
    logic                out_fire;
    logic                in_fire;
    assign at_end        = idx == LAST_IDX;
    assign m_axis_tvalid = busy;
    assign m_axis_tdata  = hold[idx*OUT_WIDTH +: OUT_WIDTH];
    assign m_axis_tlast  = busy && hold_last && at_end;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    // Accepting on the final slice's handshake keeps the narrow side gap-free
    assign s_axis_tready = !busy || (out_fire && at_end);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold      <= '0;
            hold_last <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            if (in_fire) begin
                hold      <= s_axis_tdata;
                hold_last <= s_axis_tlast;
                idx       <= '0;
                busy      <= 1'b1;
            end else if (out_fire) begin
                busy <= !at_end;
                idx  <= at_end ? '0 : idx + 1'b1;
            end
            if (out_fire && m_axis_tlast)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_out_downsizer.sv
// tb_axis_out_downsizer: directed and randomised checks of the 128->64 downsizer, plus a 2-bit frame counter instance
module tb_axis_out_downsizer;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [63:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready = 1'b1;
    logic [15:0]  fcnt;
    logic         s_tready2;
    logic [63:0]  m_tdata2;
    logic         m_tvalid2;
    logic         m_tlast2;
    logic [1:0]   fcnt2;
    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_out_downsizer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .frame_cnt(fcnt)
    );

    axis_out_downsizer #(.FRAME_CNT_W(2)) dut2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tlast(m_tlast2), .m_axis_tready(m_tready),
        .frame_cnt(fcnt2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    localparam logic [127:0] D1 = 128'h02000100020002000100020001000100;
    localparam logic [127:0] D2 = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

    initial begin
        logic [127:0] w [4];
        logic [64:0]  q [$];
        logic [64:0]  e;
        logic [127:0] cur;
        logic         cur_last;
        logic         in_f;
        logic         out_f;
        int           bi;
        int           sent;
        int           last_in;
        int           last_out;
        int           cyc;
        w[0] = 128'h11111111111111110000000000000000;
        w[1] = 128'h33333333333333332222222222222222;
        w[2] = 128'h55555555555555554444444444444444;
        w[3] = 128'h77777777777777776666666666666666;

        repeat (2) tick;
        @(negedge aclk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_sready", s_tready, 1);
        chk("rst_fcnt", fcnt, 0);
        aresetn = 1'b1;

        // single beat
        tick;
        s_tdata = D1; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        @(negedge aclk);
        chk("t1_sready", s_tready, 1);
        tick;
        s_tvalid = 1'b0;
        @(negedge aclk);
        chk("t1_v0", m_tvalid, 1);
        chk("t1_d0", m_tdata, 64'h0100020001000100);
        chk("t1_l0", m_tlast, 0);
        tick;
        @(negedge aclk);
        chk("t1_d1", m_tdata, 64'h0200010002000200);
        chk("t1_l1", m_tlast, 1);
        chk("t1_fcnt_pre", fcnt, 0);
        tick;
        @(negedge aclk);
        chk("t1_vend", m_tvalid, 0);
        chk("t1_fcnt", fcnt, 1);

        // back-to-back four-beat frame
        tick;
        s_tdata = w[0]; s_tlast = 1'b0; s_tvalid = 1'b1;
        tick;
        bi = 1;
        s_tdata = w[1];
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            chk($sformatf("t2_v%0d", k), m_tvalid, 1);
            chk($sformatf("t2_d%0d", k), m_tdata, w[k/2][(k%2)*64 +: 64]);
            chk($sformatf("t2_l%0d", k), m_tlast, k == 7);
            chk($sformatf("t2_sr%0d", k), s_tready, k % 2);
            tick;
            if (k % 2 == 1) begin
                bi++;
                if (bi < 4) begin
                    s_tdata = w[bi];
                    s_tlast = bi == 3;
                end else s_tvalid = 1'b0;
            end
        end
        @(negedge aclk);
        chk("t2_vend", m_tvalid, 0);
        chk("t2_fcnt", fcnt, 2);

        // backpressure on slice 1, then simultaneous release and accept
        tick;
        s_tdata = D1; s_tlast = 1'b1; s_tvalid = 1'b1;
        tick;
        s_tdata = D2;
        @(negedge aclk);
        chk("t3_d0", m_tdata, 64'h0100020001000100);
        tick;
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk($sformatf("t3_hd%0d", k), m_tdata, 64'h0200010002000200);
            chk($sformatf("t3_hv%0d", k), m_tvalid, 1);
            chk($sformatf("t3_hl%0d", k), m_tlast, 1);
            chk($sformatf("t3_hsr%0d", k), s_tready, 0);
            tick;
        end
        m_tready = 1'b1;
        @(negedge aclk);
        chk("t3_rel_sr", s_tready, 1);
        chk("t3_rel_d", m_tdata, 64'h0200010002000200);
        tick;
        s_tvalid = 1'b0;
        @(negedge aclk);
        chk("t3_n_d0", m_tdata, 64'h0123456789ABCDEF);
        chk("t3_n_l0", m_tlast, 0);
        chk("t3_fcnt_a", fcnt, 3);
        tick;
        @(negedge aclk);
        chk("t3_n_d1", m_tdata, 64'hDEADBEEFCAFEF00D);
        chk("t3_n_l1", m_tlast, 1);
        tick;
        @(negedge aclk);
        chk("t3_vend", m_tvalid, 0);
        chk("t3_fcnt_b", fcnt, 4);

        // asynchronous reset in the middle of a tlast beat
        tick;
        s_tdata = D2; s_tlast = 1'b1; s_tvalid = 1'b1;
        tick;
        s_tvalid = 1'b0;
        tick;
        @(negedge aclk);
        chk("t4_pre_l", m_tlast, 1);
        #1 aresetn = 1'b0;
        #1;
        chk("t4_v", m_tvalid, 0);
        chk("t4_l", m_tlast, 0);
        chk("t4_d", m_tdata, 0);
        chk("t4_fcnt", fcnt, 0);
        chk("t4_fcnt2", fcnt2, 0);
        chk("t4_sr", s_tready, 1);
        tick;
        tick;
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk($sformatf("t4_post_v%0d", k), m_tvalid, 0);
            chk($sformatf("t4_post_sr%0d", k), s_tready, 1);
            tick;
        end

        // five single-beat frames: 2-bit counter wraps 1,2,3,0,1
        for (int f = 1; f <= 5; f++) begin
            s_tdata = D1; s_tlast = 1'b1; s_tvalid = 1'b1;
            tick;
            s_tvalid = 1'b0;
            tick;
            tick;
            @(negedge aclk);
            chk($sformatf("t6_fcnt2_%0d", f), fcnt2, f % 4);
            chk($sformatf("t6_fcnt_%0d", f), fcnt, f);
            tick;
        end

        // random valid/ready against a slice scoreboard
        sent = 0; last_in = 0; last_out = 0; cyc = 0;
        cur = {$urandom, $urandom, $urandom, $urandom};
        cur_last = 1'b0;
        while ((sent < 200 || q.size() > 0) && cyc < 5000) begin
            s_tvalid = sent < 200 && $urandom_range(0, 3) != 0;
            s_tdata = cur;
            s_tlast = cur_last;
            m_tready = $urandom_range(0, 3) != 0;
            @(negedge aclk);
            in_f = s_tvalid && s_tready;
            out_f = m_tvalid && m_tready;
            if (in_f) begin
                q.push_back({1'b0, cur[63:0]});
                q.push_back({cur_last, cur[127:64]});
                last_in += cur_last;
            end
            if (out_f) begin
                if (q.size() == 0) chk("t5_extra_beat", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("t5_data", m_tdata, e[63:0]);
                    chk("t5_last", m_tlast, e[64]);
                    last_out += m_tlast;
                end
            end
            tick;
            cyc++;
            if (in_f) begin
                sent++;
                cur = {$urandom, $urandom, $urandom, $urandom};
                cur_last = sent == 199 || $urandom_range(0, 3) == 0;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        chk("t5_timeout", cyc < 5000, 1);
        chk("t5_sent", sent, 200);
        chk("t5_tlast_cnt", last_out, last_in);
        @(negedge aclk);
        chk("t5_fcnt", fcnt, 5 + last_in);
        chk("t5_fcnt2", fcnt2, (5 + last_in) % 4);
        chk("t5_idle", m_tvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
